digit_serial_adder: RTL and testbench

DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

---
 rtl/digit_serial_adder.sv | 127 ++++++++++++
 tb/tb_digit_serial_adder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: adds DIGIT bits per cycle with a registered carry between slices.
// Latency: busy for WIDTH/DIGIT cycles after start, then a one-cycle done pulse with the result.
// Backpressure: none; start is ignored while busy and accepted in the done cycle for back-to-back use.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_err
        $error("digit_serial_adder: DIGIT must be in 1..WIDTH and divide WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic              carry;
    logic [CW-1:0]     cnt;

    logic [DIGIT:0]    slice_sum;
    logic [DIGIT-1:0]  slice_s;
    logic              slice_c;
    logic              slice_ovf;
    logic [WIDTH-1:0]  acc_nx;
    logic              last_dig;

    // b is stored pre-inverted for subtract, so the datapath only ever adds.
    always_comb begin
        slice_sum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
                  + (DIGIT+1)'(carry);
        slice_s   = slice_sum[DIGIT-1:0];
        slice_c   = slice_sum[DIGIT];
        // carry into the MSB recovered as a ^ b ^ s at that bit position
        slice_ovf = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ slice_s[DIGIT-1] ^ slice_c;
        last_dig  = (cnt == CW'(NDIG - 1));
    end

    // Completed lower slices accumulate here; only the full word reaches sum.
    if (DIGIT == WIDTH) begin : g_single
        assign acc_nx = slice_s;
    end else begin : g_multi
        logic [WIDTH-DIGIT-1:0] acc;

        assign acc_nx = {slice_s, acc};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc <= '0;
            end else if (state == BUSY) begin
                acc <= acc_nx[WIDTH-1:DIGIT];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                        state <= BUSY;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                BUSY: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    carry <= slice_c;
                    cnt   <= cnt + CW'(1);
                    if (last_dig) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= acc_nx;
                        cout  <= slice_c;
                        ovf   <= slice_ovf;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder at 16/4, 8/1 and 8/8 with hand-computed results.
module tb_digit_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start16, cin16, sub16;
    logic [15:0] a16, b16;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    logic        start8, cin8, sub8;
    logic [7:0]  a8, b8;
    logic        busy_d1, done_d1, cout_d1, ovf_d1;
    logic [7:0]  sum_d1;
    logic        busy_d8, done_d8, cout_d8, ovf_d8;
    logic [7:0]  sum_d8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut_d1 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .busy(busy_d1), .done(done_d1), .sum(sum_d1), .cout(cout_d1), .ovf(ovf_d1)
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_dut_d8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .busy(busy_d8), .done(done_d8), .sum(sum_d8), .cout(cout_d8), .ovf(ovf_d8)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One 16-bit op; operands are scrambled after capture to show they are not re-read.
    task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic s,
                        input logic [15:0] esum, input logic ec, input logic eo);
        int nb, nd, lat;
        logic [15:0] gs;
        logic gc, go;
        nb = 0; nd = 0; lat = 0; gs = '0; gc = 1'b0; go = 1'b0;
        @(negedge clk);
        start16 = 1'b1; a16 = a; b16 = b; cin16 = ci; sub16 = s;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            start16 = 1'b0; a16 = ~a; b16 = ~b; cin16 = ~ci; sub16 = ~s;
            if (busy16) nb++;
            if (done16) begin
                nd++; lat = i; gs = sum16; gc = cout16; go = ovf16;
            end
        end
        check_eq({tag, "_busy_cycles"}, nb, 4);
        check_eq({tag, "_done_count"}, nd, 1);
        check_eq({tag, "_done_latency"}, lat, 5);
        check_eq({tag, "_sum"}, gs, esum);
        check_eq({tag, "_cout"}, gc, ec);
        check_eq({tag, "_ovf"}, go, eo);
        check_eq({tag, "_sum_held"}, sum16, esum);
    endtask

    // Drives both 8-bit instances with the same op.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic s,
                       input logic [7:0] esum, input logic ec, input logic eo);
        int nb1, nd1, lat1, nb8, nd8, lat8;
        logic [7:0] gs1, gs8;
        logic gc1, go1, gc8, go8;
        nb1 = 0; nd1 = 0; lat1 = 0; nb8 = 0; nd8 = 0; lat8 = 0;
        gs1 = '0; gs8 = '0; gc1 = 1'b0; go1 = 1'b0; gc8 = 1'b0; go8 = 1'b0;
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b; cin8 = ci; sub8 = s;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            start8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~ci; sub8 = ~s;
            if (busy_d1) nb1++;
            if (busy_d8) nb8++;
            if (done_d1) begin nd1++; lat1 = i; gs1 = sum_d1; gc1 = cout_d1; go1 = ovf_d1; end
            if (done_d8) begin nd8++; lat8 = i; gs8 = sum_d8; gc8 = cout_d8; go8 = ovf_d8; end
        end
        check_eq({tag, "_d1_busy_cycles"}, nb1, 8);
        check_eq({tag, "_d1_done_count"}, nd1, 1);
        check_eq({tag, "_d1_latency"}, lat1, 9);
        check_eq({tag, "_d1_sum"}, gs1, esum);
        check_eq({tag, "_d1_cout"}, gc1, ec);
        check_eq({tag, "_d1_ovf"}, go1, eo);
        check_eq({tag, "_d8_busy_cycles"}, nb8, 1);
        check_eq({tag, "_d8_done_count"}, nd8, 1);
        check_eq({tag, "_d8_latency"}, lat8, 2);
        check_eq({tag, "_d8_sum"}, gs8, esum);
        check_eq({tag, "_d8_cout"}, gc8, ec);
        check_eq({tag, "_d8_ovf"}, go8, eo);
    endtask

    initial begin
        int lat, lat2, nd;
        logic [15:0] gs;

        rst_n = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        #1;
        check_eq("rst_busy", busy16, 0);
        check_eq("rst_done", done16, 0);
        check_eq("rst_sum", sum16, 0);
        check_eq("rst_cout", cout16, 0);
        check_eq("rst_ovf", ovf16, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        op16("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        op16("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        op16("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op16("add_cin", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);

        // start pulsed mid-busy must be ignored; start in the done cycle chains the next op
        @(negedge clk);
        start16 = 1'b1; a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; sub16 = 1'b0;
        lat = 0; gs = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            start16 = (i == 2);
            if (i == 2) begin a16 = 16'hFFFF; b16 = 16'hFFFF; sub16 = 1'b1; end
            if (done16) begin lat = i; gs = sum16; break; end
        end
        check_eq("busy_start_latency", lat, 5);
        check_eq("busy_start_sum", gs, 16'h3333);
        start16 = 1'b1; a16 = 16'h0F0F; b16 = 16'h0101; cin16 = 1'b0; sub16 = 1'b0;
        lat2 = 0; gs = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start16 = 1'b0;
            if (i == 1) check_eq("b2b_busy_rise", busy16, 1);
            if (done16) begin lat2 = i; gs = sum16; break; end
        end
        check_eq("b2b_done_spacing", lat2, 5);
        check_eq("b2b_sum", gs, 16'h1010);

        // reset in the second busy cycle aborts the op
        @(negedge clk);
        start16 = 1'b1; a16 = 16'h0001; b16 = 16'h0002;
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", busy16, 0);
        check_eq("abort_done", done16, 0);
        check_eq("abort_sum", sum16, 0);
        check_eq("abort_cout", cout16, 0);
        check_eq("abort_ovf", ovf16, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done16) nd++;
        end
        check_eq("abort_no_done", nd, 0);
        check_eq("abort_sum_after", sum16, 0);
        op16("post_abort", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

        op8("w8_add", 8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("w8_sub", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
